srv_icache_sa: RTL and testbench
================================

Name: srv_icache_sa

Overview:
- Parametrised set-associative L1 instruction cache for the schoolRISCV fetch path; sits between core instruction fetch and the external line-refill memory port.
- Generalises the earlier fully associative 2-way cache to NSETS x NWAYS with a configurable line width.
- Adds per-set MRU-bit PLRU replacement, an explicit request-ready handshake and a full-cache invalidate (fence.i) that walks the sets.

Parameters:
- CACHE_EN, 1, 0 = every access misses, no fill, no state update.
- NWAYS, 2, ways per set, power of two, 1..8.
- NSETS, 4, sets, power of two, >=1.
- LINE_W, 128, line width in bits, power of two, >=64.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_i  in  1  fetch request, accepted when im_rdy_o=1
- imAddr  in  32  byte address; [1:0] ignored
- im_rdy_o  out  1  cache can accept a request this cycle
- imData  out  32  fetched instruction, valid when im_drdy=1
- im_drdy  out  1  one-cycle response strobe
- ext_addr_o  out  32  line-aligned refill byte address
- ext_req_o  out  1  refill request, level
- ext_rsp_i  in  1  refill data valid, one cycle
- ext_data_i  in  LINE_W  refill line
- inval_i  in  1  invalidate all lines, one-cycle pulse
- inv_busy_o  out  1  flush in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Address split:
  - OFFS_W = log2(LINE_W/8).
  - Word index = imAddr[OFFS_W-1:2].
  - Set index = imAddr[OFFS_W+log2(NSETS)-1:OFFS_W].
  - Tag = remaining upper bits.
- Storage:
  - Data and tag arrays: flops, no reset.
  - Per-set valid[NWAYS] and plru[NWAYS]: reset to 0.
- FSM states: IDLE, MISS, FLUSH. Reset -> IDLE.
- Reset values: im_drdy=0, ext_req_o=0, inv_busy_o=0, inv_pend=0, im_rdy_o=1 after reset; imData undefined.
- im_rdy_o = (state==IDLE) & ~inv_pend & ~inval_i.
- Acceptance: cycle N with imem_req_i & im_rdy_o latches the address; lookup against the tag and valid flops is combinational in cycle N.
- Hit (cycle N):
  - imData is registered; im_drdy=1 at N+1; state stays IDLE.
  - Back-to-back hits give one response per cycle.
  - Set the plru bit of the hit way.
- Miss (cycle N):
  - State is MISS at N+1; ext_req_o=1 from N+1 through the cycle ext_rsp_i is sampled, inclusive.
  - ext_addr_o = {tag, set, OFFS_W'0} of the latched address, held stable throughout MISS.
- Refill (ext_rsp_i in MISS at cycle M):
  - Write the line and tag into the victim way; set its valid and plru bits.
  - imData = selected word of ext_data_i; im_drdy=1 at M+1; state is IDLE at M+1.
- ext_rsp_i outside MISS is ignored.
- Victim selection: lowest-index invalid way; if all ways are valid, lowest-index way with plru=0.
- PLRU update: if setting a bit would make all plru bits 1, clear the others and keep only the accessed way's bit.
- NWAYS=1: the single way is always the victim.
- CACHE_EN=0:
  - Every request takes the miss path.
  - Response comes from ext_data_i.
  - Arrays, valid and plru are never written.
- Invalidate:
  - inval_i in any state sets inv_pend.
  - FLUSH is entered from IDLE when inv_pend=1; requests are blocked through im_rdy_o.
  - FLUSH clears valid and plru of one set per cycle, set 0 first: NSETS cycles, inv_busy_o=1 throughout.
  - Return to IDLE; clear inv_pend on entry to FLUSH.
  - inval_i during MISS: the refill completes and responds normally, then flush starts.
  - inval_i during FLUSH re-arms inv_pend, so a second full walk follows.
- Simultaneous inval_i and imem_req_i in IDLE: im_rdy_o=0, so the request is not accepted and the requester must hold it.
- Reset mid-MISS or mid-FLUSH:
  - IDLE next cycle, all valid bits 0, ext_req_o=0, no im_drdy.
  - A late ext_rsp_i is ignored.

Test Plan:
- Cold miss: NSETS=4, NWAYS=2, LINE_W=128. Request 0x0000_0014 -> ext_req_o=1 at N+1 with ext_addr_o=0x0000_0010. Return line with word1=0xDEAD_BEEF -> im_drdy and imData=0xDEAD_BEEF one cycle after ext_rsp_i.
- Hit after fill: request 0x0000_001C -> im_drdy at N+1 with word3 of that line, ext_req_o stays 0. Four back-to-back hits -> four consecutive im_drdy cycles.
- Replacement, all three lines mapping to set 1:
  - Fill 0x010, 0x050; hit 0x010; miss 0x090.
  - 0x090 evicts way holding 0x050.
  - Re-request 0x050 -> miss; 0x010 then misses next.
- Invalidate: after fills, pulse inval_i -> inv_busy_o high exactly 4 cycles, im_rdy_o low. Previously cached 0x010 then misses.
- inval_i asserted during MISS -> refill response delivered, then 4-cycle flush; the refilled line misses afterwards.
- CACHE_EN=0: same address requested twice -> two ext_req_o transactions, data correct each time. Reset asserted mid-MISS -> ext_req_o=0 next cycle, stray ext_rsp_i produces no im_drdy.

Source files
------------

// File: rtl/srv_icache_sa.sv
// rtl/srv_icache_sa.sv - set-associative L1 instruction cache with PLRU replacement and fence.i flush
//
// Purpose: NSETS x NWAYS instruction cache between the core fetch port and a
// line-refill memory port. A hit answers one cycle after acceptance. A miss
// requests the whole line, writes it into the victim way and answers from the
// returned line. inval_i walks all sets and clears them, one set per cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   imem_req_i    fetch request, taken when im_rdy_o=1
//   imAddr        fetch byte address ([1:0] ignored)
//   im_rdy_o      cache can take a request this cycle
//   imData        fetched instruction, valid with im_drdy
//   im_drdy       one-cycle response strobe
//   ext_addr_o    line-aligned refill address
//   ext_req_o     refill request (level, held until ext_rsp_i)
//   ext_rsp_i     refill line valid (one cycle)
//   ext_data_i    refill line
//   inval_i       invalidate-all pulse
//   inv_busy_o    flush walk in progress
module srv_icache_sa #(
  parameter bit CACHE_EN = 1'b1,
  parameter int NWAYS    = 2,
  parameter int NSETS    = 4,
  parameter int LINE_W   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req_i,
  input  logic [31:0]       imAddr,
  output logic              im_rdy_o,
  output logic [31:0]       imData,
  output logic              im_drdy,
  output logic [31:0]       ext_addr_o,
  output logic              ext_req_o,
  input  logic              ext_rsp_i,
  input  logic [LINE_W-1:0] ext_data_i,
  input  logic              inval_i,
  output logic              inv_busy_o
);

  localparam int OFFS_W = $clog2(LINE_W / 8);
  localparam int WI_W   = OFFS_W - 2;
  localparam int LOG2S  = $clog2(NSETS);
  localparam int SI_W   = (LOG2S > 0) ? LOG2S : 1;
  localparam int TAG_W  = 32 - OFFS_W - LOG2S;
  localparam int WAY_W  = (NWAYS > 1) ? $clog2(NWAYS) : 1;

  typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_t;

  state_t state, state_nx;

  logic [LINE_W-1:0] data_q  [NSETS][NWAYS];
  logic [TAG_W-1:0]  tag_q   [NSETS][NWAYS];
  logic [NWAYS-1:0]  valid_q [NSETS];
  logic [NWAYS-1:0]  plru_q  [NSETS];

  logic [31:0]      addr_q;
  logic             inv_pend;
  logic [SI_W-1:0]  flush_cnt;

  logic [SI_W-1:0]  lk_set, rf_set;
  logic [TAG_W-1:0] lk_tag;
  logic             hit, have_victim;
  logic [WAY_W-1:0] hit_way, victim;
  logic             accept, refill;

  // Masking instead of slicing keeps NSETS=1 legal (set index is always 0).
  function automatic logic [SI_W-1:0] set_of(input logic [31:0] a);
    return SI_W'(a >> OFFS_W) & SI_W'(NSETS - 1);
  endfunction

  function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line,
                                          input logic [WI_W-1:0]   wi);
    return line[32*int'(wi) +: 32];
  endfunction

  // MRU-bit PLRU: mark the accessed way; if that would mark every way,
  // restart the history with only the accessed way marked.
  function automatic logic [NWAYS-1:0] plru_touch(input logic [NWAYS-1:0] old,
                                                  input logic [WAY_W-1:0] way);
    logic [NWAYS-1:0] oh, nx;
    oh      = '0;
    oh[way] = 1'b1;
    nx      = old | oh;
    return (&nx) ? oh : nx;
  endfunction

  // Lookup of the incoming address, combinational in the accept cycle.
  always_comb begin
    lk_set  = set_of(imAddr);
    lk_tag  = imAddr[31 -: TAG_W];
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!hit && valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    if (!CACHE_EN) hit = 1'b0;
  end

  // Victim for the line being refilled: first invalid way, else first way
  // whose MRU bit is clear, else way 0 (only reachable with NWAYS=1).
  always_comb begin
    rf_set      = set_of(addr_q);
    victim      = '0;
    have_victim = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!have_victim && !valid_q[rf_set][w]) begin
        victim      = WAY_W'(w);
        have_victim = 1'b1;
      end
    end
    for (int w = 0; w < NWAYS; w++) begin
      if (!have_victim && !plru_q[rf_set][w]) begin
        victim      = WAY_W'(w);
        have_victim = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    im_rdy_o   = (state == IDLE) && !inv_pend && !inval_i;
    accept     = imem_req_i && im_rdy_o;
    refill     = (state == MISS) && ext_rsp_i;
    ext_req_o  = (state == MISS);
    inv_busy_o = (state == FLUSH);
    case (state)
      IDLE: begin
        if (inv_pend)           state_nx = FLUSH;
        else if (accept && !hit) state_nx = MISS;
      end
      MISS:    if (ext_rsp_i) state_nx = IDLE;
      FLUSH:   if (flush_cnt == SI_W'(NSETS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ext_addr_o = {addr_q[31:OFFS_W], {OFFS_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      inv_pend  <= 1'b0;
      flush_cnt <= '0;
      im_drdy   <= 1'b0;
    end else begin
      state   <= state_nx;
      im_drdy <= (accept && hit) || refill;
      // A new pulse wins over the clear, so inval_i during FLUSH queues another walk.
      if (inval_i)                                 inv_pend <= 1'b1;
      else if (state == IDLE && state_nx == FLUSH) inv_pend <= 1'b0;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q <= imAddr;
    if (accept && hit) imData <= word_of(data_q[lk_set][hit_way], imAddr[2 +: WI_W]);
    else if (refill)   imData <= word_of(ext_data_i, addr_q[2 +: WI_W]);
    if (CACHE_EN && refill && !rst) begin
      data_q[rf_set][victim] <= ext_data_i;
      tag_q[rf_set][victim]  <= addr_q[31 -: TAG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (state == FLUSH) begin
      valid_q[flush_cnt] <= '0;
      plru_q[flush_cnt]  <= '0;
    end else if (CACHE_EN && refill) begin
      valid_q[rf_set][victim] <= 1'b1;
      plru_q[rf_set]          <= plru_touch(plru_q[rf_set], victim);
    end else if (accept && hit) begin
      plru_q[lk_set] <= plru_touch(plru_q[lk_set], hit_way);
    end
  end

endmodule

// File: tb/tb_srv_icache_sa.sv
// tb/tb_srv_icache_sa.sv - self-checking bench for srv_icache_sa (4 sets, 2 ways, 128-bit lines)
//
// Purpose: drives directed and random fetches into a cached instance and a
// CACHE_EN=0 instance, plays the refill memory, and compares responses with
// a line/set/way model of the cache kept in plain arrays.
// Ports: none (top-level bench).
module tb_srv_icache_sa;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_i, im_rdy_o, im_drdy, ext_req_o, ext_rsp_i, inval_i, inv_busy_o;
  logic [31:0]   imAddr, imData, ext_addr_o;
  logic [LW-1:0] ext_data_i;

  logic          d0_req, d0_rdy, d0_drdy, d0_ext_req, d0_rsp, d0_inval, d0_busy;
  logic [31:0]   d0_addr, d0_data, d0_ext_addr;
  logic [LW-1:0] d0_ext_data;

  int vectors     = 0;
  int miscompares = 0;

  srv_icache_sa #(.CACHE_EN(1'b1), .NWAYS(NW), .NSETS(NS), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst), .imem_req_i(imem_req_i), .imAddr(imAddr), .im_rdy_o(im_rdy_o),
    .imData(imData), .im_drdy(im_drdy), .ext_addr_o(ext_addr_o), .ext_req_o(ext_req_o),
    .ext_rsp_i(ext_rsp_i), .ext_data_i(ext_data_i), .inval_i(inval_i), .inv_busy_o(inv_busy_o)
  );

  srv_icache_sa #(.CACHE_EN(1'b0), .NWAYS(NW), .NSETS(NS), .LINE_W(LW)) dut0 (
    .clk(clk), .rst(rst), .imem_req_i(d0_req), .imAddr(d0_addr), .im_rdy_o(d0_rdy),
    .imData(d0_data), .im_drdy(d0_drdy), .ext_addr_o(d0_ext_addr), .ext_req_o(d0_ext_req),
    .ext_rsp_i(d0_rsp), .ext_data_i(d0_ext_data), .inval_i(d0_inval), .inv_busy_o(d0_busy)
  );

  always #5 clk = ~clk;

  // Backing memory, filled lazily with random words.
  int unsigned mem [int unsigned];

  // Cache model: per set/way valid, tag (line address / NS) and MRU bit.
  bit          mv [NS][NW];
  bit          mp [NS][NW];
  int unsigned mt [NS][NW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_word(input logic [31:0] a);
    int unsigned k = a >> 2;
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [31:0] a);
    logic [LW-1:0] l;
    logic [31:0]   base = a & ~32'hF;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = get_word(base + 32'(4 * k));
    return l;
  endfunction

  function automatic void touch(input int s, input int w);
    bit all = 1'b1;
    mp[s][w] = 1'b1;
    for (int i = 0; i < NW; i++) all &= mp[s][i];
    if (all) for (int i = 0; i < NW; i++) mp[s][i] = (i == w);
  endfunction

  // Returns 1 on hit; on a miss installs the line in the victim way.
  function automatic bit model_access(input logic [31:0] a);
    int          s = int'((a / 16) % NS);
    int unsigned t = a / (16 * NS);
    int          w = -1;
    for (int i = 0; i < NW; i++) if (w < 0 && mv[s][i] && mt[s][i] == t) w = i;
    if (w >= 0) begin
      touch(s, w);
      return 1'b1;
    end
    for (int i = 0; i < NW; i++) if (w < 0 && !mv[s][i]) w = i;
    for (int i = 0; i < NW; i++) if (w < 0 && !mp[s][i]) w = i;
    if (w < 0) w = 0;
    mv[s][w] = 1'b1;
    mt[s][w] = t;
    touch(s, w);
    return 1'b0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0;
        mp[s][w] = 1'b0;
      end
  endfunction

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic fetch(input logic [31:0] a);
    bit          h;
    logic [31:0] ew;
    int          gap;
    for (int k = 0; k < 50 && im_rdy_o !== 1'b1; k++) @(negedge clk);
    h  = model_access(a);
    ew = get_word(a & ~32'h3);
    imem_req_i = 1'b1;
    imAddr     = a;
    #1;
    chk("im_rdy", 32'(im_rdy_o), 1);
    @(negedge clk);
    imem_req_i = 1'b0;
    imAddr     = $urandom;
    if (h) begin
      chk("hit_drdy", 32'(im_drdy), 1);
      chk("hit_data", imData, ew);
      chk("hit_noreq", 32'(ext_req_o), 0);
    end else begin
      chk("miss_req", 32'(ext_req_o), 1);
      chk("miss_addr", ext_addr_o, a & ~32'hF);
      chk("miss_nodrdy", 32'(im_drdy), 0);
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(negedge clk);
        chk("miss_hold_req", 32'(ext_req_o), 1);
        chk("miss_hold_addr", ext_addr_o, a & ~32'hF);
      end
      ext_rsp_i  = 1'b1;
      ext_data_i = line_of(a);
      @(negedge clk);
      ext_rsp_i = 1'b0;
      chk("fill_drdy", 32'(im_drdy), 1);
      chk("fill_data", imData, ew);
      chk("fill_req_off", 32'(ext_req_o), 0);
    end
  endtask

  task automatic burst(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      bit          h;
      a = base + 32'(4 * i);
      h = model_access(a);
      imem_req_i = 1'b1;
      imAddr     = a;
      @(negedge clk);
      chk("burst_drdy", 32'(im_drdy), 32'(h));
      chk("burst_data", imData, get_word(a));
      chk("burst_noreq", 32'(ext_req_o), 0);
    end
    imem_req_i = 1'b0;
  endtask

  // Optionally pulses inval_i, then counts busy cycles over a fixed window.
  task automatic flush_window(input bit pulse, input bit rearm, input int n_exp);
    int n = 0;
    if (pulse) begin
      inval_i = 1'b1;
      #1;
      chk("inval_blocks_rdy", 32'(im_rdy_o), 0);
      @(negedge clk);
      inval_i = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      inval_i = 1'b0;
      if (inv_busy_o) begin
        n++;
        chk("flush_rdy_low", 32'(im_rdy_o), 0);
        if (rearm && n == 2) inval_i = 1'b1;
      end
    end
    chk("flush_cycles", n, n_exp);
    chk("post_flush_rdy", 32'(im_rdy_o), 1);
    model_flush();
  endtask

  task automatic fetch0(input logic [31:0] a);
    logic [31:0] ew;
    ew = get_word(a & ~32'h3);
    for (int k = 0; k < 50 && d0_rdy !== 1'b1; k++) @(negedge clk);
    d0_req  = 1'b1;
    d0_addr = a;
    #1;
    chk("d0_rdy", 32'(d0_rdy), 1);
    @(negedge clk);
    d0_req = 1'b0;
    chk("d0_req", 32'(d0_ext_req), 1);
    chk("d0_addr", d0_ext_addr, a & ~32'hF);
    chk("d0_nodrdy", 32'(d0_drdy), 0);
    d0_rsp      = 1'b1;
    d0_ext_data = line_of(a);
    @(negedge clk);
    d0_rsp = 1'b0;
    chk("d0_drdy", 32'(d0_drdy), 1);
    chk("d0_data", d0_data, ew);
    chk("d0_req_off", 32'(d0_ext_req), 0);
  endtask

  initial begin
    rst = 1'b1;
    imem_req_i = 1'b0; imAddr = '0; ext_rsp_i = 1'b0; ext_data_i = '0; inval_i = 1'b0;
    d0_req = 1'b0; d0_addr = '0; d0_rsp = 1'b0; d0_ext_data = '0; d0_inval = 1'b0;
    model_flush();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(im_rdy_o), 1);
    chk("rst_drdy", 32'(im_drdy), 0);
    chk("rst_ext_req", 32'(ext_req_o), 0);
    chk("rst_busy", 32'(inv_busy_o), 0);
    chk("rst_d0_rdy", 32'(d0_rdy), 1);
    @(negedge clk);

    // Cold miss, then hits in the same line.
    mem[32'h14 >> 2] = 32'hDEAD_BEEF;
    fetch(32'h0000_0014);
    fetch(32'h0000_001C);
    burst(32'h0000_0010);

    // Replacement in set 1.
    fetch(32'h010);
    fetch(32'h050);
    fetch(32'h010);
    fetch(32'h090);
    fetch(32'h050);
    fetch(32'h010);

    // Full invalidate, then re-armed invalidate.
    flush_window(1'b1, 1'b0, NS);
    fetch(32'h010);
    flush_window(1'b1, 1'b1, 2 * NS);

    // inval_i during a refill.
    fetch(32'h090);
    void'(model_access(32'h010));
    imem_req_i = 1'b1;
    imAddr     = 32'h010;
    @(negedge clk);
    imem_req_i = 1'b0;
    chk("mi_req", 32'(ext_req_o), 1);
    inval_i = 1'b1;
    @(negedge clk);
    inval_i = 1'b0;
    chk("mi_req_hold", 32'(ext_req_o), 1);
    chk("mi_not_busy", 32'(inv_busy_o), 0);
    ext_rsp_i  = 1'b1;
    ext_data_i = line_of(32'h010);
    @(negedge clk);
    ext_rsp_i = 1'b0;
    chk("mi_drdy", 32'(im_drdy), 1);
    chk("mi_data", imData, get_word(32'h010));
    flush_window(1'b0, 1'b0, NS);
    fetch(32'h010);

    // Random traffic with occasional invalidates.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 24) == 0) flush_window(1'b1, 1'b0, NS);
      else fetch($urandom_range(0, 32'h17F));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset in the middle of a miss; a late response must be ignored.
    imem_req_i = 1'b1;
    imAddr     = 32'h200;
    @(negedge clk);
    imem_req_i = 1'b0;
    chk("rm_req", 32'(ext_req_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_req_off", 32'(ext_req_o), 0);
    chk("rm_nodrdy", 32'(im_drdy), 0);
    chk("rm_rdy", 32'(im_rdy_o), 1);
    ext_rsp_i  = 1'b1;
    ext_data_i = line_of(32'h200);
    @(negedge clk);
    ext_rsp_i = 1'b0;
    chk("stray_nodrdy", 32'(im_drdy), 0);
    chk("stray_noreq", 32'(ext_req_o), 0);
    model_flush();
    fetch(32'h010);

    // Cache disabled: every access refills, same address twice.
    fetch0(32'h0000_0024);
    fetch0(32'h0000_0024);
    fetch0(32'h0000_0138);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
